bp_table: RTL

- Parametrised successor to the single saturating-counter predictor.
- Holds a table of 2^INDEX_BITS saturating counters, indexed by PC bits optionally XORed with a global history register (gshare).
- Gives a registered taken/not-taken prediction one cycle after a lookup, and is trained by a separate resolve/update port from the branch unit.
- Sits between fetch (lookup) and execute (update); also counts mispredictions.

---
 rtl/bp_table_if.sv | 33 +++
 rtl/bp_table.sv | 134 +++++++++++++
 2 files changed

// File: rtl/bp_table_if.sv
// Fetch/branch-unit side bundle for the branch prediction table:
// lookup request, registered prediction, resolve/update and debug/stat outputs.
interface bp_table_if #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 6,
    parameter int HIST_BITS  = 4,
    parameter int STAT_WIDTH = 16
);
    localparam int GHR_W = (HIST_BITS > 0) ? HIST_BITS : 1;

    logic                  ready;
    logic                  req_valid;
    logic [PC_WIDTH-1:0]   req_pc;
    logic                  pred_valid;
    logic                  pred_taken;
    logic [INDEX_BITS-1:0] pred_index;
    logic                  upd_valid;
    logic [INDEX_BITS-1:0] upd_index;
    logic                  upd_taken;
    logic                  upd_mispredict;
    logic [GHR_W-1:0]      ghr;
    logic [STAT_WIDTH-1:0] mispredict_count;

    modport master (
        output req_valid, req_pc, upd_valid, upd_index, upd_taken, upd_mispredict,
        input  ready, pred_valid, pred_taken, pred_index, ghr, mispredict_count
    );

    modport slave (
        input  req_valid, req_pc, upd_valid, upd_index, upd_taken, upd_mispredict,
        output ready, pred_valid, pred_taken, pred_index, ghr, mispredict_count
    );
endinterface

// File: rtl/bp_table.sv
// Table of saturating counters indexed by PC (optionally XORed with global history),
// with registered prediction, non-speculative training and a mispredict counter.
module bp_table #(
    parameter int CTR_WIDTH  = 2,
    parameter int INDEX_BITS = 6,
    parameter int HIST_BITS  = 4,
    parameter int PC_WIDTH   = 32,
    parameter int STAT_WIDTH = 16
) (
    input logic       clk,
    input logic       reset,
    bp_table_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int GHR_W   = (HIST_BITS > 0) ? HIST_BITS : 1;
    localparam logic [CTR_WIDTH-1:0] INIT_VAL = {1'b0, {(CTR_WIDTH-1){1'b1}}};

    typedef enum logic {S_INIT_SWEEP, S_RUN} state_t;

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] sweep_ptr_q, sweep_ptr_d;
    logic [GHR_W-1:0]      ghr_q, ghr_d;
    logic [STAT_WIDTH-1:0] miss_q, miss_d;
    logic                  pred_valid_q, pred_valid_d;
    logic                  pred_taken_q, pred_taken_d;
    logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
    logic [CTR_WIDTH-1:0]  ctr_q [ENTRIES];
    logic [CTR_WIDTH-1:0]  ctr_d [ENTRIES];

    logic [INDEX_BITS-1:0] hist_xor;
    logic [GHR_W-1:0]      ghr_shift;
    logic [INDEX_BITS-1:0] lookup_index;
    logic                  unused_pc_bits;

    assign unused_pc_bits = ^{bus.req_pc[PC_WIDTH-1:INDEX_BITS+2], bus.req_pc[1:0]};

    generate
        if (HIST_BITS == 0) begin : g_bimodal
            assign hist_xor  = '0;
            assign ghr_shift = '0;
        end else if (HIST_BITS == 1) begin : g_hist1
            assign hist_xor  = INDEX_BITS'(ghr_q);
            assign ghr_shift = bus.upd_taken;
        end else begin : g_histn
            assign hist_xor  = INDEX_BITS'(ghr_q);
            assign ghr_shift = {ghr_q[HIST_BITS-2:0], bus.upd_taken};
        end
    endgenerate

    assign lookup_index = bus.req_pc[INDEX_BITS+1:2] ^ hist_xor;

    // Counter array next value: sweep write during init, saturating train in RUN.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            ctr_d[i] = ctr_q[i];
            if (!reset) begin
                if (state_q == S_INIT_SWEEP) begin
                    if (sweep_ptr_q == INDEX_BITS'(i))
                        ctr_d[i] = INIT_VAL;
                end else if (bus.upd_valid && bus.upd_index == INDEX_BITS'(i)) begin
                    if (bus.upd_taken) begin
                        if (ctr_q[i] != {CTR_WIDTH{1'b1}})
                            ctr_d[i] = ctr_q[i] + CTR_WIDTH'(1);
                    end else begin
                        if (ctr_q[i] != '0)
                            ctr_d[i] = ctr_q[i] - CTR_WIDTH'(1);
                    end
                end
            end
        end
    end

    // Prediction reads ctr_d, so a same-cycle update to the looked-up entry is seen.
    always_comb begin
        state_d      = state_q;
        sweep_ptr_d  = sweep_ptr_q;
        ghr_d        = ghr_q;
        miss_d       = miss_q;
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        pred_index_d = pred_index_q;
        case (state_q)
            S_INIT_SWEEP: begin
                sweep_ptr_d = sweep_ptr_q + INDEX_BITS'(1);
                if (sweep_ptr_q == {INDEX_BITS{1'b1}})
                    state_d = S_RUN;
            end
            default: begin
                pred_valid_d = bus.req_valid;
                if (bus.req_valid) begin
                    pred_taken_d = ctr_d[lookup_index][CTR_WIDTH-1];
                    pred_index_d = lookup_index;
                end
                if (bus.upd_valid) begin
                    ghr_d = ghr_shift;
                    if (bus.upd_mispredict && miss_q != {STAT_WIDTH{1'b1}})
                        miss_d = miss_q + STAT_WIDTH'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_INIT_SWEEP;
            sweep_ptr_q  <= '0;
            ghr_q        <= '0;
            miss_q       <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_index_q <= '0;
        end else begin
            state_q      <= state_d;
            sweep_ptr_q  <= sweep_ptr_d;
            ghr_q        <= ghr_d;
            miss_q       <= miss_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_index_q <= pred_index_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++)
            ctr_q[i] <= ctr_d[i];
    end

    assign bus.ready            = (state_q == S_RUN);
    assign bus.pred_valid       = pred_valid_q;
    assign bus.pred_taken       = pred_taken_q;
    assign bus.pred_index       = pred_index_q;
    assign bus.ghr              = ghr_q;
    assign bus.mispredict_count = miss_q;
endmodule
